// File: rtl/demux_stream_pkg.sv
// Shared defaults and helpers for the 1-to-NCH streaming demultiplexer.
package demux_stream_pkg;

    localparam int DEF_W   = 8;
    localparam int DEF_NCH = 4;

    // True when sel addresses an existing channel.
    function automatic logic sel_valid(input logic [31:0] sel, input logic [31:0] nch);
        return (sel < nch);
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry registered slice with valid/ready handshake; push and pop may coincide.
module demux_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop_ready,
    output logic         valid,
    output logic [W-1:0] data,
    output logic         free
);

    logic         valid_d, valid_q;
    logic [W-1:0] data_d, data_q;

    // Next-state: a push wins over a pop; data is kept after a pop.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (push) begin
            valid_d = 1'b1;
            data_d  = push_data;
        end else if (pop_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Slot state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= {W{1'b0}};
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
    assign free  = !valid_q || pop_ready;

endmodule

// File: rtl/demux_stream.sv
// Streaming 1-to-NCH demultiplexer: unicast by select, broadcast to all,
// sticky error on out-of-range select.
module demux_stream
    import demux_stream_pkg::*;
#(
    parameter int W   = DEF_W,
    parameter int NCH = DEF_NCH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W-1:0]             in_data,
    input  logic [$clog2(NCH)-1:0]   in_sel,
    input  logic                     in_bcast,
    output logic [NCH-1:0]           out_valid,
    input  logic [NCH-1:0]           out_ready,
    output logic [NCH*W-1:0]         out_data,
    output logic                     err
);

    localparam int SELW = $clog2(NCH);

    logic [NCH-1:0] free_s;
    logic [NCH-1:0] sel_hit_s;
    logic [NCH-1:0] push_s;
    logic           sel_ok_s;
    logic           in_ready_s;
    logic           xfer_s;
    logic           err_d, err_q;

    // Acceptance decision and push fan-out for the current input beat.
    always_comb begin
        sel_ok_s  = sel_valid(32'(in_sel), 32'(NCH));
        sel_hit_s = {NCH{1'b0}};
        for (int k = 0; k < NCH; k++) begin
            sel_hit_s[k] = (32'(in_sel) == 32'(k));
        end

        in_ready_s = 1'b0;
        if (!en) begin
            in_ready_s = 1'b0;
        end else if (in_bcast) begin
            in_ready_s = &free_s;
        end else if (sel_ok_s) begin
            in_ready_s = |(sel_hit_s & free_s);
        end else begin
            // Out-of-range beats are swallowed so the producer never stalls on them.
            in_ready_s = 1'b1;
        end

        xfer_s = in_valid && in_ready_s;
        push_s = {NCH{1'b0}};
        if (xfer_s) begin
            push_s = in_bcast ? {NCH{1'b1}} : sel_hit_s;
        end else begin
            push_s = {NCH{1'b0}};
        end

        err_d = err_q || (xfer_s && !in_bcast && !sel_ok_s);
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    genvar g;
    generate
        for (g = 0; g < NCH; g++) begin : g_slot
            demux_slot #(.W(W)) u_slot (
                .clk       (clk),
                .rst_n     (rst_n),
                .push      (push_s[g]),
                .push_data (in_data),
                .pop_ready (out_ready[g]),
                .valid     (out_valid[g]),
                .data      (out_data[g*W +: W]),
                .free      (free_s[g])
            );
        end
    endgenerate

    assign in_ready = in_ready_s;
    assign err      = err_q;

endmodule

// File: doc/demux_stream.md
Name: demux_stream

Overview:
Parametrised 1-to-NCH streaming demultiplexer. It is the successor to our combinational 1-to-4 demux, generalised to a W-bit data path and NCH channels. Each input beat is routed by a select field to one output channel, or broadcast to all channels. Every output has a one-entry registered slot with a valid/ready handshake. The block sits between a single producer and NCH independent consumers.

Parameters:
W, 8, data width in bits (>=1)
NCH, 4, number of output channels (2..16; need not be a power of two)
SELW, $clog2(NCH), select width; derived localparam, not overridable

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous, active-low reset
en  input  1  global enable; when low, no new input beat is accepted
in_valid  input  1  producer has a beat
in_ready  output  1  block accepts the beat this cycle (combinational)
in_data  input  W  payload
in_sel  input  SELW  target channel index
in_bcast  input  1  1 = deliver the beat to all NCH channels
out_valid  output  NCH  per-channel slot holds a beat
out_ready  input  NCH  per-channel consumer accepts
out_data  output  NCH*W  channel k occupies bits [k*W +: W]
err  output  1  sticky flag: a beat with in_sel >= NCH was seen

Behaviour:
- Reset: when rst_n is low, out_valid=0, out_data=0 and err=0 immediately, asynchronously. Any beats held in the slots are discarded. Reset may assert mid-transfer; the first handshake is possible in the first cycle after rst_n deasserts.
- Slot free condition: slot k can take a beat when !out_valid[k] || out_ready[k]. A pop and a push of slot k in the same cycle are allowed.
- in_ready, combinational, is defined by cases:
  - en=0: in_ready=0.
  - en=1, in_bcast=1: in_ready=1 only if all slots are free.
  - en=1, in_bcast=0, in_sel<NCH: in_ready = free(in_sel).
  - en=1, in_bcast=0, in_sel>=NCH: in_ready=1.
- Transfer: a transfer occurs when in_valid && in_ready.
  - Unicast: slot in_sel loads in_data and sets out_valid.
  - Broadcast: every slot loads in_data and sets out_valid in the same cycle.
  - Invalid select (in_sel>=NCH, unicast): the beat is consumed and dropped, and err is set to 1. err holds until reset. in_bcast=1 overrides in_sel, so no error is raised.
- Latency: exactly 1 cycle from the input handshake to out_valid.
- Throughput: one beat per cycle per channel when consumers hold out_ready=1.
- Pop: out_ready[k] && out_valid[k] with no push clears out_valid[k]. out_data[k] keeps its last value; it is not cleared.
- Stability: while out_valid[k]=1 and out_ready[k]=0, out_data[k] and out_valid[k] must not change.
- Enable: when en is low, slots still drain normally; only acceptance is blocked.
- No combinational path exists from out_ready to out_valid or out_data. in_ready does depend combinationally on out_ready.
- Source contract: in_data, in_sel and in_bcast are held stable while in_valid=1 and in_ready=0. The block does not check this.

Decomposition:
- Package demux_stream_pkg: default W and NCH constants, plus a function sel_valid(sel, nch).
- Sub-module demux_slot (parameter W): one-entry register slice.
  - Ports: clk, rst_n, push, push_data, pop_ready, valid, data, free.
  - The top instantiates NCH slots in a generate loop.
  - The top contains the in_ready logic, push fan-out and err register.

Test Plan:
- Reset then unicast: W=8, NCH=4, en=1, out_ready=4'b1111, send in_sel=2, in_data=8'hA5 -> next cycle out_valid=4'b0100, out_data[2]=8'hA5. Other slots stay invalid.
- Backpressure: out_ready[1]=0, send two beats to ch1 (8'h11, 8'h22) -> first accepted; in_ready=0 on the second. Raise out_ready[1] -> 8'h11 pops, 8'h22 is accepted the same cycle and appears 1 cycle later.
- Broadcast: hold out_ready[3]=0 with slot 3 full, send in_bcast=1, in_data=8'h3C -> in_ready=0. Release out_ready[3] -> all four out_valid bits set next cycle with 8'h3C.
- Invalid select: NCH=3, send in_sel=3, in_data=8'hFF -> in_ready=1, no out_valid change, err=1 from the next cycle and sticky. Then in_bcast=1 with in_sel=3 -> no additional error effect.
- Enable and mid-stream reset: en=0 with in_valid=1 -> in_ready=0 while full slots still drain. Assert rst_n=0 while slots 0 and 1 are full -> out_valid=0 and err=0 without waiting for a clock edge.
- Streaming: rotate in_sel 0,1,2,3 for 16 consecutive cycles with all ready -> one beat per cycle, each delivered in order 1 cycle later, no stalls.
